hc_ccip_mem_responder: RTL and testbench
========================================

Name: hc_ccip_mem_responder

Overview:
- Synthesizable CCI-P host-memory responder: the far end of the requestor/MPF traffic.
- Accepts c0 read-line and c1 write-line requests (t_if_ccip_Tx).
- Returns read data and write acks on c0/c1 Rx (t_if_ccip_Rx), backed by on-chip line RAM.
- Sits in place of the FIU in host-less loopback benches and on-board self-test builds.

Parameters:
- MEM_LINES, 1024: 512-bit lines in backing RAM; power of 2.
- FIFO_DEPTH, 16: per-channel request FIFO entries; power of 2, at least 8.
- ALMFULL_MARGIN, 4: free entries remaining when TxAlmFull asserts.

Ports:
- clk  input  1  single clock domain.
- reset  input  1  asynchronous, active-low.
- ccip_tx  input  t_if_ccip_Tx  requests: c0 read, c1 write; c2 ignored.
- ccip_rx  output  t_if_ccip_Rx  responses plus c0TxAlmFull/c1TxAlmFull; c0.mmioRdValid/mmioWrValid tied 0.
- rd_count  output  32  read responses issued; wraps.
- wr_count  output  32  write acks issued; wraps.

Behaviour:
- Reset (async assert, sync deassert internally): all ccip_rx valid/rspValid 0; AlmFull 0; counters 0; FIFOs empty; RAM contents undefined.
- Line index: idx = hdr.address[$clog2(MEM_LINES)-1:0]. Upper address bits are ignored, so addresses alias modulo MEM_LINES.
- Request acceptance, c0:
  - c0.valid with req_type eREQ_RDLINE_I or eREQ_RDLINE_S pushes {idx, mdata} into rd FIFO.
  - Other req_types are dropped.
- Request acceptance, c1:
  - c1.valid with eREQ_WRLINE_I or eREQ_WRLINE_M pushes {idx, mdata, data} into wr FIFO.
  - eREQ_WRFENCE pushes a fence entry.
  - Other req_types are dropped.
- cl_len: only eCL_LEN_1 is supported. Nonzero cl_len is treated as 1 line and raises a sticky internal error flag (visible to bench via hierarchy).
- AlmFull: cNTxAlmFull = 1 when the FIFO count is at least FIFO_DEPTH-ALMFULL_MARGIN. It is registered, so it updates the cycle after the count changes.
- Overflow: a push into a full FIFO is dropped and sets the same sticky error. The requestor must honour AlmFull; the margin covers its pipeline.
- Read path (fixed latency):
  - Pop at T; RAM read at T+1; c0.rspValid at T+2 with resp_type eRSP_RDLINE, mdata echoed, cl_num 0, hit_miss 0, vc_used eVC_VL0, data = line.
  - One pop per cycle max, so throughput is 1 line/clk.
- Write path:
  - Pop at T writes RAM at T (edge ending T).
  - c1.rspValid at T+1 with resp_type eRSP_WRLINE, mdata echoed, format 0, cl_num 0.
  - A fence pop produces eRSP_WRFENCE with mdata echoed at T+1, and is popped only when no write is in flight (always true here, so fence latency equals write latency).
- Simultaneous read and write pop, same idx, same cycle: read returns OLD data (read-first RAM). Cross-channel ordering is not guaranteed, per CCI-P.
- c0 and c1 responses may be valid in the same cycle; they are independent channels.
- Counters increment on each rspValid, including fence acks in wr_count, and wrap at 2^32.
- Reset asserted mid-operation: in-flight responses are discarded, and no rspValid appears after reset deasserts until new requests arrive.

Optional Feature:
- HC_MEM_RSP_RANDOM_STALL_EN defined:
  - 16-bit LFSR per channel, seed 16'hACE1 on reset.
  - A pop is suppressed in any cycle where LFSR[1:0]==2'b00, giving variable latency to stress AlmFull/backpressure handling.
  - Responses stay in order within a channel.
- Undefined: pops occur whenever the FIFO is non-empty, with fixed latencies as above.

Decomposition:
- hc_pkg gains:
  - HC_MEM_RSP_RD_LATENCY=2 and HC_MEM_RSP_WR_LATENCY=1.
  - t_hc_mem_rd_entry {idx, mdata}.
  - t_hc_mem_wr_entry {is_fence, idx, mdata, data}.
- One sub-module: hc_mem_rsp_fifo. It is a parameterized sync FIFO (type/width, DEPTH, ALMFULL_MARGIN) with count, full, empty and registered almfull. It is instantiated twice.
- RAM is inferred inline.

Test Plan:
- Write-then-read: write idx 5, data 512'h0123...CDEF, mdata 16'h0011 -> c1 ack mdata 16'h0011 at +1 after pop. Then read idx 5, mdata 16'h0022 -> c0 data matches, mdata 16'h0022, 2 cycles after pop; rd_count=1, wr_count=1.
- Aliasing: write address 1029 with MEM_LINES=1024 -> a read of address 5 returns that data.
- Same-cycle collision: prefill idx 7 = A. Pop write idx 7 = B and read idx 7 together -> read returns A; a subsequent read returns B.
- Backpressure: push 12 reads back-to-back (DEPTH 16, margin 4) with pops stalled by holding the feature's stall -> c0TxAlmFull rises the cycle after count reaches 12. The 17th push sets the error flag. All 16 accepted responses return in order with correct mdata.
- Fence: write, write, fence (mdata 16'h00FF) -> two eRSP_WRLINE acks, then eRSP_WRFENCE with mdata 16'h00FF; wr_count=3.
- Reset mid-stream: assert reset with 4 reads queued -> no rspValid while reset is low or after it deasserts; counters 0; AlmFull 0.

Source files
------------

// File: rtl/hc_ccip_mem_responder_pkg.sv
// Types and constants for the CCI-P host-memory responder: a trimmed CCI-P
// Tx/Rx channel model plus the responder's internal FIFO entry formats.
package hc_ccip_mem_responder_pkg;

    localparam int HC_MEM_RSP_RD_LATENCY = 2;
    localparam int HC_MEM_RSP_WR_LATENCY = 1;
    localparam int HC_MEM_IDX_W          = 20;
    localparam int CCIP_ADDR_W           = 42;
    localparam int CCIP_MDATA_W          = 16;
    localparam int CCIP_DATA_W           = 512;

    typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_ccip_vc;
    typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;

    typedef enum logic [3:0] {eREQ_RDLINE_I = 4'h0, eREQ_RDLINE_S = 4'h1} t_ccip_c0_req;
    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4, eREQ_INTR     = 4'h6
    } t_ccip_c1_req;
    typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
    typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;

    typedef struct packed {
        t_ccip_vc                vc_sel;
        t_ccip_clLen             cl_len;
        t_ccip_c0_req            req_type;
        logic [CCIP_ADDR_W-1:0]  address;
        logic [CCIP_MDATA_W-1:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc                vc_sel;
        logic                    sop;
        t_ccip_clLen             cl_len;
        t_ccip_c1_req            req_type;
        logic [CCIP_ADDR_W-1:0]  address;
        logic [CCIP_MDATA_W-1:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_vc                vc_used;
        logic                    hit_miss;
        logic [1:0]              cl_num;
        t_ccip_c0_rsp            resp_type;
        logic [CCIP_MDATA_W-1:0] mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_vc                vc_used;
        logic                    hit_miss;
        logic                    format;
        logic [1:0]              cl_num;
        t_ccip_c1_rsp            resp_type;
        logic [CCIP_MDATA_W-1:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr     hdr;
        logic [CCIP_DATA_W-1:0] data;
        logic                   valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0]  tid;
        logic [63:0] data;
        logic        mmioRdValid;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr     hdr;
        logic [CCIP_DATA_W-1:0] data;
        logic                   rspValid;
        logic                   mmioRdValid;
        logic                   mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [HC_MEM_IDX_W-1:0] idx;
        logic [CCIP_MDATA_W-1:0] mdata;
    } t_hc_mem_rd_entry;

    typedef struct packed {
        logic                    is_fence;
        logic [HC_MEM_IDX_W-1:0] idx;
        logic [CCIP_MDATA_W-1:0] mdata;
        logic [CCIP_DATA_W-1:0]  data;
    } t_hc_mem_wr_entry;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length).
    function automatic logic [15:0] hc_lfsr_next(logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/hc_ccip_mem_responder_if.sv
// CCI-P request/response bundle between a requestor (master) and the
// memory responder (slave).
interface hc_ccip_mem_responder_if;
    import hc_ccip_mem_responder_pkg::*;

    t_if_ccip_Tx ccip_tx;
    t_if_ccip_Rx ccip_rx;

    modport master (output ccip_tx, input ccip_rx);
    modport slave  (input ccip_tx, output ccip_rx);
endinterface

// File: rtl/hc_mem_rsp_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a registered
// almost-full flag; pushes into a full FIFO are dropped and flagged.
module hc_mem_rsp_fifo #(
    parameter type T              = logic [7:0],
    parameter int  DEPTH          = 16,
    parameter int  ALMFULL_MARGIN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   almfull,
    output logic                   ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] AF_CNT   = (PW + 1)'(DEPTH - ALMFULL_MARGIN);

    T              mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign ovf     = push && full;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            almfull <= 1'b0;
        end else begin
            wptr    <= wptr + PW'(do_push);
            rptr    <= rptr + PW'(do_pop);
            count   <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
            // Looks at the current count, so it trails occupancy by a cycle.
            almfull <= (count >= AF_CNT);
        end
    end
endmodule

// File: rtl/hc_ccip_mem_responder.sv
// CCI-P host-memory responder backed by on-chip line RAM: c0 reads, c1 writes
// and fences. Define HC_MEM_RSP_RANDOM_STALL_EN for LFSR-driven pop stalls.
module hc_ccip_mem_responder
    import hc_ccip_mem_responder_pkg::*;
#(
    parameter int MEM_LINES      = 1024,
    parameter int FIFO_DEPTH     = 16,
    parameter int ALMFULL_MARGIN = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    hc_ccip_mem_responder_if.slave  ccip,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    t_if_ccip_Tx      tx;
    t_if_ccip_Rx      rx;
    t_hc_mem_rd_entry rd_din, rd_head;
    t_hc_mem_wr_entry wr_din, wr_head;
    logic             rd_req, wr_req, fence_req, len_err;
    logic             rd_pop, wr_pop, rd_stall, wr_stall;
    logic             rd_empty, wr_empty, rd_full, wr_full;
    logic             rd_almfull, wr_almfull, rd_ovf, wr_ovf;
    logic [CW-1:0]    rd_cnt, wr_cnt;
    logic             err;

    assign tx = ccip.ccip_tx;

    assign rd_req    = tx.c0.valid && (tx.c0.hdr.req_type == eREQ_RDLINE_I ||
                                       tx.c0.hdr.req_type == eREQ_RDLINE_S);
    assign wr_req    = tx.c1.valid && (tx.c1.hdr.req_type == eREQ_WRLINE_I ||
                                       tx.c1.hdr.req_type == eREQ_WRLINE_M);
    assign fence_req = tx.c1.valid && (tx.c1.hdr.req_type == eREQ_WRFENCE);
    assign len_err   = (rd_req && tx.c0.hdr.cl_len != eCL_LEN_1) ||
                       (wr_req && tx.c1.hdr.cl_len != eCL_LEN_1);

    always_comb begin
        rd_din          = '0;
        rd_din.idx      = HC_MEM_IDX_W'(tx.c0.hdr.address[IDX_W-1:0]);
        rd_din.mdata    = tx.c0.hdr.mdata;
        wr_din          = '0;
        wr_din.is_fence = fence_req;
        wr_din.idx      = HC_MEM_IDX_W'(tx.c1.hdr.address[IDX_W-1:0]);
        wr_din.mdata    = tx.c1.hdr.mdata;
        wr_din.data     = tx.c1.data;
    end

    hc_mem_rsp_fifo #(.T(t_hc_mem_rd_entry), .DEPTH(FIFO_DEPTH), .ALMFULL_MARGIN(ALMFULL_MARGIN)) u_rd_fifo (
        .clk(clk), .rst_n(rst_n), .push(rd_req), .din(rd_din), .pop(rd_pop), .dout(rd_head),
        .count(rd_cnt), .full(rd_full), .empty(rd_empty), .almfull(rd_almfull), .ovf(rd_ovf)
    );

    hc_mem_rsp_fifo #(.T(t_hc_mem_wr_entry), .DEPTH(FIFO_DEPTH), .ALMFULL_MARGIN(ALMFULL_MARGIN)) u_wr_fifo (
        .clk(clk), .rst_n(rst_n), .push(wr_req || fence_req), .din(wr_din), .pop(wr_pop), .dout(wr_head),
        .count(wr_cnt), .full(wr_full), .empty(wr_empty), .almfull(wr_almfull), .ovf(wr_ovf)
    );

`ifdef HC_MEM_RSP_RANDOM_STALL_EN
    logic [15:0] rd_lfsr, wr_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_lfsr <= 16'hACE1;
            wr_lfsr <= 16'hACE1;
        end else begin
            rd_lfsr <= hc_lfsr_next(rd_lfsr);
            wr_lfsr <= hc_lfsr_next(wr_lfsr);
        end
    end
    assign rd_stall = (rd_lfsr[1:0] == 2'b00);
    assign wr_stall = (wr_lfsr[1:0] == 2'b00);
`else
    assign rd_stall = 1'b0;
    assign wr_stall = 1'b0;
`endif

    // Writes retire into RAM on their pop edge, so nothing is ever in flight
    // when a fence reaches the head; fences pop like any other entry.
    assign rd_pop = !rd_empty && !rd_stall;
    assign wr_pop = !wr_empty && !wr_stall;

    logic [CCIP_DATA_W-1:0] mem [MEM_LINES];
    logic [CCIP_DATA_W-1:0] ram_q, rd_data_q;
    logic [CCIP_MDATA_W-1:0] rd_mdata_s1, rd_mdata_q, wr_mdata_q;
    logic                    wr_fence_q, wr_vld;
    logic [HC_MEM_RSP_RD_LATENCY-1:0] rd_vld_pipe;

    // Read-first: a read popped alongside a same-index write sees old data.
    always_ff @(posedge clk) begin
        if (wr_pop && !wr_head.is_fence) mem[wr_head.idx[IDX_W-1:0]] <= wr_head.data;
        if (rd_pop) ram_q <= mem[rd_head.idx[IDX_W-1:0]];
        if (rd_vld_pipe[0]) rd_data_q <= ram_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_pipe <= '0;
            rd_mdata_s1 <= '0;
            rd_mdata_q  <= '0;
            wr_vld      <= 1'b0;
            wr_mdata_q  <= '0;
            wr_fence_q  <= 1'b0;
            rd_count    <= '0;
            wr_count    <= '0;
            err         <= 1'b0;
        end else begin
            rd_vld_pipe <= {rd_vld_pipe[HC_MEM_RSP_RD_LATENCY-2:0], rd_pop};
            if (rd_pop)         rd_mdata_s1 <= rd_head.mdata;
            if (rd_vld_pipe[0]) rd_mdata_q  <= rd_mdata_s1;
            wr_vld <= wr_pop;
            if (wr_pop) begin
                wr_mdata_q <= wr_head.mdata;
                wr_fence_q <= wr_head.is_fence;
            end
            rd_count <= rd_count + 32'(rd_vld_pipe[0]);
            wr_count <= wr_count + 32'(wr_pop);
            err      <= err | len_err | rd_ovf | wr_ovf;
        end
    end

    always_comb begin
        rx                  = '0;
        rx.c0TxAlmFull      = rd_almfull;
        rx.c1TxAlmFull      = wr_almfull;
        rx.c0.hdr.vc_used   = eVC_VL0;
        rx.c0.hdr.resp_type = eRSP_RDLINE;
        rx.c0.hdr.mdata     = rd_mdata_q;
        rx.c0.data          = rd_data_q;
        rx.c0.rspValid      = rd_vld_pipe[HC_MEM_RSP_RD_LATENCY-1];
        rx.c1.hdr.vc_used   = eVC_VL0;
        rx.c1.hdr.resp_type = wr_fence_q ? eRSP_WRFENCE : eRSP_WRLINE;
        rx.c1.hdr.mdata     = wr_mdata_q;
        rx.c1.rspValid      = wr_vld;
    end
    assign ccip.ccip_rx = rx;

    logic unused_ok;
    assign unused_ok = ^{tx.c2, tx.c0.hdr.vc_sel, tx.c1.hdr.vc_sel, tx.c1.hdr.sop,
                         tx.c0.hdr.address[CCIP_ADDR_W-1:IDX_W], tx.c1.hdr.address[CCIP_ADDR_W-1:IDX_W],
                         rd_head.idx[HC_MEM_IDX_W-1:IDX_W], wr_head.idx[HC_MEM_IDX_W-1:IDX_W],
                         rd_cnt, wr_cnt, rd_full, wr_full};
endmodule

// File: tb/tb_hc_ccip_mem_responder.sv
// Directed bench for hc_ccip_mem_responder: vector table for single requests
// plus hand-written collision, backpressure, reset and fence sequences.
module tb_hc_ccip_mem_responder;
    import hc_ccip_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rd_count, wr_count;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    hc_ccip_mem_responder_if ccip_if();

    hc_ccip_mem_responder dut (
        .clk(clk), .reset(reset), .ccip(ccip_if), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic [15:0]    mdata;
        logic [3:0]     typ;
        logic [511:0]   data;
        logic [1:0]     vc;
        logic [1:0]     cl_num;
        logic           hit;
    } rsp_t;

    rsp_t rd_q[$];
    rsp_t wr_q[$];

    always @(negedge clk) begin : mon
        rsp_t r;
        if (ccip_if.ccip_rx.c0.rspValid) begin
            r.cyc = cyc; r.mdata = ccip_if.ccip_rx.c0.hdr.mdata;
            r.typ = 4'(ccip_if.ccip_rx.c0.hdr.resp_type); r.data = ccip_if.ccip_rx.c0.data;
            r.vc = 2'(ccip_if.ccip_rx.c0.hdr.vc_used); r.cl_num = ccip_if.ccip_rx.c0.hdr.cl_num;
            r.hit = ccip_if.ccip_rx.c0.hdr.hit_miss;
            rd_q.push_back(r);
        end
        if (ccip_if.ccip_rx.c1.rspValid) begin
            r.cyc = cyc; r.mdata = ccip_if.ccip_rx.c1.hdr.mdata;
            r.typ = 4'(ccip_if.ccip_rx.c1.hdr.resp_type); r.data = '0;
            r.vc = 2'(ccip_if.ccip_rx.c1.hdr.vc_used); r.cl_num = ccip_if.ccip_rx.c1.hdr.cl_num;
            r.hit = ccip_if.ccip_rx.c1.hdr.format;
            wr_q.push_back(r);
        end
    end

    function automatic void check(string name, logic [511:0] act, logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic idle();
        ccip_if.ccip_tx = '0;
    endtask

    task automatic drive_rd(logic [41:0] addr, logic [15:0] m, logic alt, logic [1:0] len);
        ccip_if.ccip_tx.c0.valid          = 1'b1;
        ccip_if.ccip_tx.c0.hdr.req_type   = alt ? eREQ_RDLINE_S : eREQ_RDLINE_I;
        ccip_if.ccip_tx.c0.hdr.cl_len     = t_ccip_clLen'(len);
        ccip_if.ccip_tx.c0.hdr.address    = addr;
        ccip_if.ccip_tx.c0.hdr.mdata      = m;
    endtask

    task automatic drive_wr(int kind, logic [41:0] addr, logic [15:0] m, logic [511:0] d, logic alt);
        ccip_if.ccip_tx.c1.valid          = 1'b1;
        ccip_if.ccip_tx.c1.hdr.req_type   = (kind == 2) ? eREQ_WRFENCE :
                                            (kind == 4) ? eREQ_WRPUSH_I :
                                            alt ? eREQ_WRLINE_M : eREQ_WRLINE_I;
        ccip_if.ccip_tx.c1.hdr.cl_len     = eCL_LEN_1;
        ccip_if.ccip_tx.c1.hdr.sop        = 1'b1;
        ccip_if.ccip_tx.c1.hdr.address    = addr;
        ccip_if.ccip_tx.c1.hdr.mdata      = m;
        ccip_if.ccip_tx.c1.data           = d;
    endtask

    // kind: 0 read, 1 write, 2 fence, 3 bad c0 type, 4 bad c1 type
    typedef struct {
        int           kind;
        logic         alt;
        logic [41:0]  addr;
        logic [15:0]  mdata;
        logic [511:0] data;
        logic [511:0] exp_data;
        int           exp_rd;
        int           exp_wr;
    } vec_t;

    vec_t vecs[14];

    logic [511:0] D0, D1, D2, D3, A, B;

    initial begin
        int c;
        D0 = {8{64'h0123456789ABCDEF}};
        D1 = {16{32'hDEADBEEF}};
        D2 = {8{64'hFEDCBA9876543210}};
        D3 = 512'h1;
        A  = {64{8'hA5}};
        B  = {64{8'h5A}};
        vecs[0]  = '{1, 1'b0, 42'd5,    16'h0011, D0, '0, 0, 1};
        vecs[1]  = '{0, 1'b0, 42'd5,    16'h0022, '0, D0, 1, 1};
        vecs[2]  = '{1, 1'b0, 42'd1029, 16'h0033, D1, '0, 1, 2};
        vecs[3]  = '{0, 1'b1, 42'd5,    16'h0034, '0, D1, 2, 2};
        vecs[4]  = '{1, 1'b0, 42'd7,    16'h0040, A,  '0, 2, 3};
        vecs[5]  = '{0, 1'b0, 42'd2055, 16'h0041, '0, A,  3, 3};
        vecs[6]  = '{3, 1'b0, 42'd7,    16'h0042, '0, '0, 3, 3};
        vecs[7]  = '{4, 1'b0, 42'd7,    16'h0043, D2, '0, 3, 3};
        vecs[8]  = '{0, 1'b1, 42'd7,    16'h0044, '0, A,  4, 3};
        vecs[9]  = '{1, 1'b0, 42'd1023, 16'h0045, D2, '0, 4, 4};
        vecs[10] = '{0, 1'b0, 42'd1023, 16'h0046, '0, D2, 5, 4};
        vecs[11] = '{1, 1'b1, 42'd0,    16'h0047, D3, '0, 5, 5};
        vecs[12] = '{0, 1'b0, 42'd1024, 16'h0048, '0, D3, 6, 5};
        vecs[13] = '{2, 1'b0, 42'd0,    16'h0049, '0, '0, 6, 6};

        idle();
        tick(3);
        reset = 1'b1;
        tick(5);
        check("reset c0 rspValid", ccip_if.ccip_rx.c0.rspValid, 0);
        check("reset c1 rspValid", ccip_if.ccip_rx.c1.rspValid, 0);
        check("reset mmio valids", {ccip_if.ccip_rx.c0.mmioRdValid, ccip_if.ccip_rx.c0.mmioWrValid}, 0);
        check("reset almfull", {ccip_if.ccip_rx.c0TxAlmFull, ccip_if.ccip_rx.c1TxAlmFull}, 0);
        check("reset counts", {rd_count, wr_count}, 0);
        check("reset err", dut.err, 0);

        for (int i = 0; i < 14; i++) begin
            rd_q.delete(); wr_q.delete();
            c = cyc;
            case (vecs[i].kind)
                0: drive_rd(vecs[i].addr, vecs[i].mdata, vecs[i].alt, 2'b00);
                3: begin
                    drive_rd(vecs[i].addr, vecs[i].mdata, 1'b0, 2'b00);
                    ccip_if.ccip_tx.c0.hdr.req_type = t_ccip_c0_req'(4'h2);
                end
                default: drive_wr(vecs[i].kind, vecs[i].addr, vecs[i].mdata, vecs[i].data, vecs[i].alt);
            endcase
            tick(1);
            idle();
            tick(8);
            if (vecs[i].kind == 0) begin
                check($sformatf("v%0d rd rsps", i), rd_q.size(), 1);
                check($sformatf("v%0d wr rsps", i), wr_q.size(), 0);
                if (rd_q.size() > 0) begin
                    check($sformatf("v%0d rd latency", i), rd_q[0].cyc, c + 3);
                    check($sformatf("v%0d rd mdata", i), rd_q[0].mdata, vecs[i].mdata);
                    check($sformatf("v%0d rd type", i), rd_q[0].typ, 4'h0);
                    check($sformatf("v%0d rd hdr", i), {rd_q[0].vc, rd_q[0].cl_num, rd_q[0].hit}, 5'b01_00_0);
                    check($sformatf("v%0d rd data", i), rd_q[0].data, vecs[i].exp_data);
                end
            end else if (vecs[i].kind <= 2) begin
                check($sformatf("v%0d wr rsps", i), wr_q.size(), 1);
                check($sformatf("v%0d rd rsps", i), rd_q.size(), 0);
                if (wr_q.size() > 0) begin
                    check($sformatf("v%0d wr latency", i), wr_q[0].cyc, c + 2);
                    check($sformatf("v%0d wr mdata", i), wr_q[0].mdata, vecs[i].mdata);
                    check($sformatf("v%0d wr type", i), wr_q[0].typ, (vecs[i].kind == 2) ? 4'h4 : 4'h0);
                    check($sformatf("v%0d wr hdr", i), {wr_q[0].cl_num, wr_q[0].hit}, 3'b000);
                end
            end else begin
                check($sformatf("v%0d dropped", i), rd_q.size() + wr_q.size(), 0);
            end
            check($sformatf("v%0d rd_count", i), rd_count, vecs[i].exp_rd);
            check($sformatf("v%0d wr_count", i), wr_count, vecs[i].exp_wr);
        end

        // Same-cycle read and write of idx 7 (holds A): read sees A, then B.
        rd_q.delete(); wr_q.delete();
        c = cyc;
        drive_rd(42'd7, 16'h0050, 1'b0, 2'b00);
        drive_wr(1, 42'd7, 16'h0051, B, 1'b0);
        tick(1); idle(); tick(8);
        check("coll rd rsps", rd_q.size(), 1);
        check("coll wr rsps", wr_q.size(), 1);
        if (rd_q.size() > 0) begin
            check("coll rd old data", rd_q[0].data, A);
            check("coll rd latency", rd_q[0].cyc, c + 3);
        end
        if (wr_q.size() > 0) check("coll wr latency", wr_q[0].cyc, c + 2);
        rd_q.delete();
        drive_rd(42'd7, 16'h0052, 1'b0, 2'b00);
        tick(1); idle(); tick(8);
        check("coll reread rsps", rd_q.size(), 1);
        if (rd_q.size() > 0) check("coll reread new data", rd_q[0].data, B);
        check("coll counts", {rd_count, wr_count}, {32'd8, 32'd7});

        // Backpressure: hold the read stall and push 17 reads back-to-back.
        rd_q.delete();
        force dut.rd_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            check($sformatf("bp almfull at push %0d", i), ccip_if.ccip_rx.c0TxAlmFull, (i >= 13) ? 1 : 0);
            if (i == 16) check("bp err before ovf", dut.err, 0);
            drive_rd(42'(i), 16'h0100 + 16'(i), 1'b0, 2'b00);
            tick(1);
        end
        idle();
        check("bp err after ovf", dut.err, 1);
        check("bp almfull held", ccip_if.ccip_rx.c0TxAlmFull, 1);
        tick(3);
        check("bp no rsp while stalled", rd_q.size(), 0);
        release dut.rd_stall;
        tick(30);
        check("bp rsp count", rd_q.size(), 16);
        for (int j = 0; j < 16 && j < rd_q.size(); j++) begin
            check($sformatf("bp mdata %0d", j), rd_q[j].mdata, 16'h0100 + 16'(j));
            check($sformatf("bp back-to-back %0d", j), rd_q[j].cyc, rd_q[0].cyc + j);
        end
        check("bp almfull drained", ccip_if.ccip_rx.c0TxAlmFull, 0);
        check("bp rd_count", rd_count, 24);

        // Reset with four reads queued behind the stall.
        force dut.rd_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_rd(42'(i), 16'h0200 + 16'(i), 1'b0, 2'b00);
            tick(1);
        end
        idle();
        tick(2);
        rd_q.delete(); wr_q.delete();
        reset = 1'b0;
        #1;
        check("rst low c0 rspValid", ccip_if.ccip_rx.c0.rspValid, 0);
        check("rst low counts", {rd_count, wr_count}, 0);
        tick(3);
        release dut.rd_stall;
        reset = 1'b1;
        tick(10);
        check("rst no rsps", rd_q.size() + wr_q.size(), 0);
        check("rst counts", {rd_count, wr_count}, 0);
        check("rst almfull", {ccip_if.ccip_rx.c0TxAlmFull, ccip_if.ccip_rx.c1TxAlmFull}, 0);
        check("rst err cleared", dut.err, 0);

        // Fence after two writes: acks in order, fence last.
        wr_q.delete();
        c = cyc;
        drive_wr(1, 42'd3, 16'h0061, D0, 1'b0); tick(1);
        drive_wr(1, 42'd4, 16'h0062, D1, 1'b1); tick(1);
        drive_wr(2, 42'd0, 16'h00FF, '0, 1'b0); tick(1);
        idle(); tick(8);
        check("fence rsp count", wr_q.size(), 3);
        for (int j = 0; j < 3 && j < wr_q.size(); j++) begin
            check($sformatf("fence latency %0d", j), wr_q[j].cyc, c + 2 + j);
            check($sformatf("fence type %0d", j), wr_q[j].typ, (j == 2) ? 4'h4 : 4'h0);
        end
        if (wr_q.size() == 3) check("fence mdata", wr_q[2].mdata, 16'h00FF);
        check("fence wr_count", wr_count, 3);

        // Multi-line cl_len: served as one line, sticky error raised.
        rd_q.delete();
        drive_rd(42'd3, 16'h0070, 1'b0, 2'b01);
        tick(1); idle(); tick(8);
        check("cllen rsps", rd_q.size(), 1);
        if (rd_q.size() > 0) begin
            check("cllen mdata", rd_q[0].mdata, 16'h0070);
            check("cllen data", rd_q[0].data, D0);
        end
        check("cllen err", dut.err, 1);
        check("cllen rd_count", rd_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
